// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side PC controller; requests imem at pc, waits for the handshake,
// then strobes the PC update with pc+4 or a redirect target, trapping on timeout/misalignment.
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned MAX_WAIT     = 8
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        stall,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        imem_ready,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] pc,
   output logic [31:0] next_pc,
   output logic        pc_enable,
   output logic        ir_load,
   output logic        squash,
   output logic        fetch_fault
);
   typedef enum logic [2:0] {IDLE, FETCH, WAIT, ADVANCE, FAULT} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, tgt_q, tgt_d;
   logic        pend_q, pend_d, held_q, held_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        live, active, adv, redir, first;
   logic [31:0] live_tgt;

   assign live      = jump | branch_taken;
   assign live_tgt  = jump ? jump_target : branch_target;
   assign active    = state_q inside {FETCH, WAIT, ADVANCE};
   assign adv       = state_q == ADVANCE;
   assign redir     = pend_q | (adv & live);
   // held_q marks stalled ADVANCE cycles so the ir_load/squash strobe fires only once
   assign first     = adv & ~held_q;
   assign next_pc   = pend_q ? tgt_q : (adv & live) ? live_tgt : pc_q + 32'd4;
   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign imem_req  = state_q == FETCH || state_q == WAIT;
   assign ir_load   = first & ~redir;
   assign squash    = first & redir;
   assign pc_enable = adv & ~stall & (next_pc[1:0] == 2'b00);
   assign fetch_fault = state_q == FAULT;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      held_d  = 1'b0;
      if (active && !pend_q && live) begin
         pend_d = 1'b1;
         tgt_d  = live_tgt;
      end
      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + 8'd1;
            if (imem_ready) state_d = ADVANCE;
            else if (cnt_d == 8'(MAX_WAIT)) state_d = FAULT;
         end
         ADVANCE: begin
            if (stall) held_d = 1'b1;
            else if (next_pc[1:0] != 2'b00) state_d = FAULT;
            else begin
               pc_d    = next_pc;
               pend_d  = 1'b0;
               state_d = FETCH;
            end
         end
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_VECTOR;
         tgt_q   <= '0;
         pend_q  <= 1'b0;
         held_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         pend_q  <= pend_d;
         held_q  <= held_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized fetch transactions against a per-instruction reference model;
// expected fetches, strobes, PC updates and faults are queued and checked by a monitor.
module tb_pc_sequencer;
   localparam logic [31:0] RV = 32'h0000_0000;
   localparam int MW = 8;

   logic        clk = 1'b0, clr_n = 1'b1, stall = 1'b0, jump = 1'b0, branch_taken = 1'b0, imem_ready = 1'b0;
   logic [31:0] jump_target = '0, branch_target = '0;
   logic        imem_req, pc_enable, ir_load, squash, fetch_fault;
   logic [31:0] imem_addr, pc, next_pc;

   pc_sequencer #(.RESET_VECTOR(RV), .MAX_WAIT(MW)) dut (
      .clk(clk), .clr_n(clr_n), .stall(stall), .jump(jump), .jump_target(jump_target),
      .branch_taken(branch_taken), .branch_target(branch_target), .imem_ready(imem_ready),
      .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .next_pc(next_pc),
      .pc_enable(pc_enable), .ir_load(ir_load), .squash(squash), .fetch_fault(fetch_fault)
   );

   typedef struct {
      int          cyc;
      logic [31:0] a;
      logic [31:0] b;
   } ev_t;

   ev_t         fq[$], sq[$], eq[$], xq[$];
   ev_t         me;
   int          cyc = 0, n_chk = 0, n_pass = 0;
   logic [31:0] mpc = RV;
   logic        go = 1'b0, prev_req = 1'b0, prev_flt = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endfunction

   function automatic ev_t mk(int c, logic [31:0] a, logic [31:0] b);
      ev_t e;
      e.cyc = c;
      e.a = a;
      e.b = b;
      return e;
   endfunction

   // monitor: every DUT event must match the oldest queued expectation of its kind
   always @(negedge clk) begin
      if (!go || !clr_n) begin
         prev_req <= 1'b0;
         prev_flt <= 1'b0;
      end else begin
         if (imem_req && !prev_req) begin
            chk("fetch_expected", 64'(fq.size() != 0), 64'd1);
            if (fq.size() != 0) begin
               me = fq.pop_front();
               chk("fetch_cyc_addr", {cyc, imem_addr}, {me.cyc, me.a});
            end
         end
         if (ir_load || squash) begin
            chk("strobe_expected", 64'(sq.size() != 0), 64'd1);
            if (sq.size() != 0) begin
               me = sq.pop_front();
               chk("strobe_cyc_kind", {cyc, 30'b0, squash, ir_load}, {me.cyc, me.a});
            end
         end
         if (pc_enable) begin
            chk("pc_enable_expected", 64'(eq.size() != 0), 64'd1);
            if (eq.size() != 0) begin
               me = eq.pop_front();
               chk("pc_enable_cyc_pc", {cyc, pc}, {me.cyc, me.a});
               chk("next_pc", 64'(next_pc), 64'(me.b));
            end
         end
         if (fetch_fault && !prev_flt) begin
            chk("fault_expected", 64'(xq.size() != 0), 64'd1);
            if (xq.size() != 0) begin
               me = xq.pop_front();
               chk("fault_cyc_pc", {cyc, pc}, {me.cyc, me.a});
               chk("fault_imem_req", 64'(imem_req), 64'd0);
            end
         end
         prev_req <= imem_req;
         prev_flt <= fetch_fault;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr_n = 1'b0;
      go = 1'b1;
      jump = 1'b0;
      branch_taken = 1'b0;
      stall = 1'b0;
      imem_ready = 1'b0;
      #1;
      chk("rst_strobes", 64'({imem_req, pc_enable, ir_load, squash, fetch_fault}), 64'd0);
      chk("rst_pc_addr", {pc, imem_addr}, {RV, RV});
      chk("rst_next_pc", 64'(next_pc), 64'(RV + 32'd4));
      step();
      step();
      clr_n = 1'b1;
      step();
      mpc = RV;
   endtask

   task automatic fault_hold();
      for (int i = 0; i < 3; i++) begin
         jump = 1'($urandom);
         branch_taken = 1'($urandom);
         jump_target = $urandom & 32'hFFFC;
         branch_target = $urandom & 32'hFFFC;
         imem_ready = 1'($urandom);
         #1;
         chk("fault_hold", {27'b0, fetch_fault, imem_req, pc_enable, ir_load, squash, pc}, {27'b0, 5'b10000, mpc});
         step();
      end
      do_reset();
   endtask

   task automatic do_abort();
      fq.push_back(mk(cyc, mpc, 32'd0));
      imem_ready = 1'b0;
      step();
      step();
      do_reset();
   endtask

   // One instruction: w not-ready WAIT cycles, s stall cycles in ADVANCE, redirect rt
   // (1 jump, 2 branch, 3 both) in window cycle r, extra branch at r2 that must be ignored.
   task automatic do_fetch(int w, int s, int r, int rt, logic [31:0] jt, logic [31:0] bt, int r2, logic [31:0] bt2);
      int          c0, fa, len;
      logic        rd;
      logic [31:0] npc;
      c0 = cyc;
      fa = w + 2;
      len = w + s + 3;
      fq.push_back(mk(c0, mpc, 32'd0));
      if (w >= MW) begin
         xq.push_back(mk(c0 + MW + 1, mpc, 32'd0));
         for (int i = 0; i <= MW; i++) begin
            imem_ready = 1'b0;
            jump = 1'b0;
            branch_taken = 1'b0;
            stall = 1'b0;
            step();
         end
         fault_hold();
         return;
      end
      rd = rt != 0;
      npc = !rd ? mpc + 32'd4 : ((rt & 1) != 0) ? jt : bt;
      sq.push_back(mk(c0 + fa, (rd && r <= fa) ? 32'd2 : 32'd1, 32'd0));
      if (npc[1:0] != 2'b00) xq.push_back(mk(c0 + len, mpc, 32'd0));
      else eq.push_back(mk(c0 + len - 1, mpc, npc));
      for (int i = 0; i < len; i++) begin
         imem_ready = (i == w + 1) ? 1'b1 : (i >= 1 && i <= w) ? 1'b0 : 1'($urandom);
         stall = i >= fa && i < fa + s;
         jump = rd && i == r && (rt & 1) != 0;
         branch_taken = (rd && i == r && (rt & 2) != 0) || i == r2;
         jump_target = jump ? jt : $urandom;
         branch_target = (i == r2) ? bt2 : bt;
         step();
      end
      jump = 1'b0;
      branch_taken = 1'b0;
      stall = 1'b0;
      if (npc[1:0] != 2'b00) fault_hold();
      else mpc = npc;
   endtask

   initial begin
      step();
      do_reset();
      do_fetch(0, 0, -1, 0, 0, 0, -1, 0);
      do_fetch(0, 0, -1, 0, 0, 0, -1, 0);
      do_fetch(2, 0, 2, 1, 32'h100, 0, -1, 0);
      do_fetch(0, 2, 2, 3, 32'h200, 32'h300, 4, 32'h400);
      do_fetch(1, 4, -1, 0, 0, 0, -1, 0);
      do_fetch(0, 0, 1, 1, 32'hFFFF_FFFC, 0, -1, 0);
      do_fetch(0, 0, -1, 0, 0, 0, -1, 0);
      do_fetch(0, 0, -1, 0, 0, 0, -1, 0);
      do_fetch(0, 0, 2, 2, 0, 32'h102, -1, 0);
      do_fetch(MW, 0, -1, 0, 0, 0, -1, 0);
      do_abort();
      for (int n = 0; n < 40; n++) begin
         int k, w, s, r, rt, r2;
         logic [31:0] jt, bt, bt2;
         k = int'($urandom_range(0, 19));
         if (k == 0) do_abort();
         else if (k == 1) do_fetch(MW, 0, -1, 0, 0, 0, -1, 0);
         else begin
            w = (k < 6) ? int'($urandom_range(0, MW - 1)) : int'($urandom_range(0, 1));
            s = (k % 2 == 1) ? int'($urandom_range(0, 3)) : 0;
            rt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
            r = int'($urandom_range(0, w + s + 2));
            jt = $urandom & 32'h0000_FFFC;
            bt = $urandom & 32'h0000_FFFC;
            bt2 = $urandom & 32'h0000_FFFC;
            if (k == 2) begin
               jt = jt | 32'd1;
               bt = bt | 32'd2;
            end
            r2 = (rt != 0 && r < w + s + 2 && $urandom_range(0, 1) == 1) ? int'($urandom_range(r + 1, w + s + 2)) : -1;
            do_fetch(w, s, r, rt, jt, bt, r2, bt2);
         end
      end
      clr_n = 1'b0;
      step();
      step();
      chk("fetch_q_drained", 64'(fq.size()), 64'd0);
      chk("strobe_q_drained", 64'(sq.size()), 64'd0);
      chk("enable_q_drained", 64'(eq.size()), 64'd0);
      chk("fault_q_drained", 64'(xq.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller that sequences the program counter register: it issues instruction-memory requests at the current PC, waits for the memory handshake, then pulses a PC-update enable with the selected next address. Next address is PC+4, a jump target or a branch target. Sits between the control unit and the PC register and instruction memory. Squashes fetches overtaken by a redirect, honours pipeline stalls, and traps on memory timeout or misaligned targets.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- MAX_WAIT, 8, max cycles in WAIT without imem_ready before fault (1..255)
- clk  input  1  system clock, rising edge
- clr_n  input  1  asynchronous active-low reset
- stall  input  1  hold PC update while high
- jump  input  1  jump redirect request
- jump_target  input  32  jump destination
- branch_taken  input  1  branch redirect request
- branch_target  input  32  branch destination
- imem_ready  input  1  instruction memory data valid / request accepted
- imem_req  output  1  instruction fetch request
- imem_addr  output  32  fetch address (= pc)
- pc  output  32  current PC register
- next_pc  output  32  address to be loaded at next pc_enable
- pc_enable  output  1  one-cycle PC update strobe
- ir_load  output  1  one-cycle instruction-register load strobe
- squash  output  1  one-cycle strobe: fetched word discarded
- fetch_fault  output  1  sticky fault flag

## Operation
- States: IDLE, FETCH, WAIT, ADVANCE, FAULT.
- IDLE: entered on reset; all strobes low; unconditionally -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc; wait counter cleared; -> WAIT.
- WAIT: imem_req=1; counter increments each cycle. imem_ready=1 -> ADVANCE. Counter reaching MAX_WAIT with imem_ready=0 -> FAULT.
- ADVANCE: first cycle asserts ir_load if no redirect is pending, else squash (exactly one of the two per fetch). If stall=1: hold ADVANCE, pc_enable=0, strobes not repeated. If stall=0: pc_enable=1, pc <= next_pc, pending cleared, -> FETCH.
- Redirect capture: in FETCH, WAIT or ADVANCE, a live jump or branch_taken with no pending redirect latches a pending target. Jump beats branch when both are high in the same cycle. Once pending, further redirects are ignored until consumed.
- next_pc: pending target if pending. Else the live redirect target in ADVANCE (jump > branch). Else pc+4, modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Misaligned: if the selected target has [1:0] != 0 in a non-stalled ADVANCE cycle -> FAULT; pc_enable=0, pc unchanged.
- FAULT: fetch_fault=1, imem_req=0, all strobes 0, pc frozen; redirects ignored. Exits only via reset.
- Redirects in IDLE are ignored.

## Timing
- Reset (clr_n low, asynchronous): state=IDLE, pc=RESET_VECTOR, pending cleared, counter=0. imem_req, pc_enable, ir_load, squash and fetch_fault are 0. imem_addr=RESET_VECTOR; next_pc=RESET_VECTOR+4.
- Reset mid-operation (any state) aborts immediately; no strobe may glitch high.
- All state, pc, pending and strobe flags are registered. imem_addr and next_pc are combinational from registered state and live redirect inputs.
- Zero-wait memory (imem_ready high in the first WAIT cycle): 3 cycles per instruction (FETCH, WAIT, ADVANCE); pc_enable period = 3 cycles.
- Each extra WAIT cycle adds 1 cycle. Each stall cycle in ADVANCE adds 1 cycle.
- pc takes the new value on the clock edge ending the pc_enable cycle. imem_addr shows it in the following FETCH.
- Fault on timeout: FAULT entered on the edge after the MAX_WAIT-th WAIT cycle without ready.
- imem_ready outside WAIT is ignored.

## Test plan
- Reset, release clr_n, imem_ready tied 1 -> imem_addr sequence 0x0, 0x4, 0x8; pc_enable every 3rd cycle; ir_load once per fetch; squash never.
- jump=1, jump_target=0x100 during WAIT of fetch at 0x8 -> squash in ADVANCE, no ir_load; pc becomes 0x100; next FETCH addr 0x100.
- jump (0x200) and branch_taken (0x300) both high in one ADVANCE cycle -> pc=0x200. A second branch during pending is ignored.
- stall high 4 cycles in ADVANCE -> pc_enable delayed exactly 4 cycles; ir_load pulses once; pc advances by 4 once.
- imem_ready held 0, MAX_WAIT=8 -> FAULT after 8 WAIT cycles; fetch_fault=1, imem_req=0; recovers only after clr_n pulse (pc=RESET_VECTOR).
- branch_target=0x102 taken -> FAULT, pc unchanged. Separately, pc=0xFFFF_FFFC with no redirect -> next pc 0x0.
